// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns one command at a time into a single non-pipelined
// AHB-Lite transfer and returns the result on a response handshake.
//
// Ports:
//   HCLK, HRESETn                         clock, synchronous active-low reset
//   cmd_valid/cmd_ready                   command handshake
//   cmd_write, cmd_addr, cmd_size, cmd_wdata
//                                         command fields, sampled on accept
//   rsp_valid/rsp_ready                   response handshake
//   rsp_rdata, rsp_err                    response payload
//   HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA
//                                         AHB-Lite master outputs
//   HREADY, HRDATA, HRESP                 AHB-Lite slave returns
module ahb_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_haddr, r_hwdata, r_rdata;
  logic        r_hwrite, r_err;
  logic [2:0]  r_hsize;

  logic        w_accept, w_misal, w_capture;
  logic [31:0] w_wdata_rep, w_lane;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_capture = (r_state == S_DATA) && HREADY;

  // Alignment check on the incoming command; size codes above word are rejected.
  always_comb begin
    w_misal = 1'b0;
    case (cmd_size)
      3'd0:    w_misal = 1'b0;
      3'd1:    w_misal = cmd_addr[0];
      3'd2:    w_misal = (cmd_addr[1:0] != 2'b00);
      default: w_misal = 1'b1;
    endcase
  end

  // Replicate narrow write data across all byte lanes so any slave lane
  // decode picks up the right bytes.
  always_comb begin
    w_wdata_rep = cmd_wdata;
    case (cmd_size)
      3'd0:    w_wdata_rep = {4{cmd_wdata[7:0]}};
      3'd1:    w_wdata_rep = {2{cmd_wdata[15:0]}};
      default: w_wdata_rep = cmd_wdata;
    endcase
  end

  // Read lane extraction uses the registered address/size, not live cmd_*.
  always_comb begin
    w_lane = HRDATA;
    case (r_hsize)
      3'd0: begin
        case (r_haddr[1:0])
          2'd0:    w_lane = {24'd0, HRDATA[7:0]};
          2'd1:    w_lane = {24'd0, HRDATA[15:8]};
          2'd2:    w_lane = {24'd0, HRDATA[23:16]};
          default: w_lane = {24'd0, HRDATA[31:24]};
        endcase
      end
      3'd1:    w_lane = r_haddr[1] ? {16'd0, HRDATA[31:16]} : {16'd0, HRDATA[15:0]};
      default: w_lane = HRDATA;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_misal ? S_RESP : S_ADDR;
      S_ADDR: if (HREADY)   w_next = S_DATA;
      S_DATA: if (HREADY)   w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default:              w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= '0;
      r_hwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_misal) begin
          // Local reject: bus-side registers keep their previous values.
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else begin
          r_haddr  <= cmd_addr;
          r_hwrite <= cmd_write;
          r_hsize  <= cmd_size;
          r_hwdata <= w_wdata_rep;
        end
      end
      if (w_capture) begin
        r_err   <= HRESP;
        r_rdata <= (!r_hwrite && !HRESP) ? w_lane : 32'd0;
      end
    end
  end

  assign cmd_ready = HRESETn && (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign HTRANS    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = r_haddr;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HWDATA    = r_hwdata;
  assign HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_ahb_cmd_master.sv
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t sb[$];

  ahb_cmd_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] rep_model(input logic [2:0] sz, input logic [31:0] wd);
    logic [7:0]  b;
    logic [15:0] h;
    b = wd[7:0];
    h = wd[15:0];
    if (sz == 3'd0) return {b, b, b, b};
    if (sz == 3'd1) return {h, h};
    return wd;
  endfunction

  function automatic logic [31:0] rdata_model(input logic wr, input logic [31:0] a,
                                              input logic [2:0] sz, input logic [31:0] rd,
                                              input logic err);
    if (wr || err) return 32'd0;
    if (sz == 3'd0) return (rd >> (8 * a[1:0])) & 32'h0000_00FF;
    if (sz == 3'd1) return (rd >> (16 * a[1])) & 32'h0000_FFFF;
    return rd;
  endfunction

  // Issues one command, plays the slave, and stops once rsp_valid is seen.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input int waits, input logic [31:0] rd,
                      input logic err,
                      output int lat, output int nonseq,
                      output logic [31:0] a_addr, output logic [2:0] a_size,
                      output logic a_write, output logic [31:0] dp_wdata,
                      output logic hw_stable, output logic dp_idle);
    lat = -1; nonseq = 0; a_addr = 0; a_size = 0; a_write = 0; dp_wdata = 0;
    hw_stable = 1'b1; dp_idle = 1'b1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    HREADY = 1'b1; HRESP = 1'b0;
    tick();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_size = 3'($urandom);
    cmd_wdata = $urandom;
    for (int c = 1; c <= 60; c++) begin
      if (HTRANS == 2'b10) begin
        nonseq++;
        if (nonseq == 1) begin a_addr = HADDR; a_size = HSIZE; a_write = HWRITE; end
      end
      if (rsp_valid) begin lat = c; break; end
      if (c >= 2 && c <= 2 + waits) begin
        if (c == 2) dp_wdata = HWDATA;
        else if (HWDATA !== dp_wdata) hw_stable = 1'b0;
        if (HTRANS !== 2'b00) dp_idle = 1'b0;
      end
      if (c >= 2 && c < 2 + waits) begin
        HREADY = 1'b0; HRESP = err && (c == 1 + waits); HRDATA = $urandom;
      end else if (c == 2 + waits) begin
        HREADY = 1'b1; HRESP = err; HRDATA = rd;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      end
      tick();
    end
    HREADY = 1'b1; HRESP = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
    checks++;
    if (HTRANS !== 2'b00 || HADDR !== 32'd0 || HWRITE !== 1'b0 || HSIZE !== 3'd0 ||
        HWDATA !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: HTRANS=%h HADDR=%h HWRITE=%b HSIZE=%h HWDATA=%h, want all 0",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: rsp_valid=%b rdata=%h err=%b cmd_ready=%b, want 0",
               rsp_valid, rsp_rdata, rsp_err, cmd_ready);
    end
    checks++;
    if (HPROT !== 4'b0011) begin
      errors++; $display("FAIL reset_hprot: got %h want 3", HPROT);
    end
    HRESETn = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_word_write();
    int lat, ns; logic [31:0] aa, dw; logic [2:0] as; logic aw, hs, di; rsp_t e;
    sb.push_back('{32'd0, 1'b0});
    xfer(1'b1, 32'h4000_0000, 3'd2, 32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b0,
         lat, ns, aa, as, aw, dw, hs, di);
    checks++;
    if (lat != 3 || ns != 1) begin
      errors++; $display("FAIL word_write_timing: lat=%0d nonseq=%0d, want 3 and 1", lat, ns);
    end
    checks++;
    if (aa !== 32'h4000_0000 || as !== 3'd2 || aw !== 1'b1) begin
      errors++; $display("FAIL word_write_addr: HADDR=%h HSIZE=%h HWRITE=%b", aa, as, aw);
    end
    checks++;
    if (dw !== 32'h1234_5678) begin
      errors++; $display("FAIL word_write_hwdata: got %h want 12345678", dw);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL word_write_rsp: rdata=%h err=%b want %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL word_write_return: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_byte_write();
    int lat, ns; logic [31:0] aa, dw; logic [2:0] as; logic aw, hs, di; rsp_t e;
    sb.push_back('{32'd0, 1'b0});
    xfer(1'b1, 32'h4000_0003, 3'd0, 32'h0000_00A5, 0, 32'h0, 1'b0,
         lat, ns, aa, as, aw, dw, hs, di);
    checks++;
    if (as !== 3'd0 || aa !== 32'h4000_0003 || dw !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL byte_write: HSIZE=%h HADDR=%h HWDATA=%h want 0 40000003 a5a5a5a5", as, aa, dw);
    end
    e = sb.pop_front();
    checks++;
    if (lat != 3 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL byte_write_rsp: lat=%0d rdata=%h err=%b", lat, rsp_rdata, rsp_err);
    end
    tick();
  endtask

  task automatic test_hw_read_wait();
    int lat, ns; logic [31:0] aa, dw; logic [2:0] as; logic aw, hs, di; rsp_t e;
    sb.push_back('{32'h0000_BEEF, 1'b0});
    xfer(1'b0, 32'h4000_0002, 3'd1, 32'h5555_AAAA, 3, 32'hBEEF_1234, 1'b0,
         lat, ns, aa, as, aw, dw, hs, di);
    checks++;
    if (lat != 6 || ns != 1) begin
      errors++; $display("FAIL hw_read_latency: lat=%0d nonseq=%0d want 6 1", lat, ns);
    end
    checks++;
    if (!hs || !di) begin
      errors++; $display("FAIL hw_read_stable: hwdata_stable=%b htrans_idle=%b want 1 1", hs, di);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL hw_read_rsp: rdata=%h err=%b want %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    tick();
  endtask

  task automatic test_error();
    int lat, ns; logic [31:0] aa, dw; logic [2:0] as; logic aw, hs, di; rsp_t e;
    int extra;
    sb.push_back('{32'd0, 1'b1});
    xfer(1'b0, 32'h4000_0010, 3'd2, 32'h0, 1, 32'hFFFF_FFFF, 1'b1,
         lat, ns, aa, as, aw, dw, hs, di);
    e = sb.pop_front();
    checks++;
    if (lat != 4 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++; $display("FAIL error_rsp: lat=%0d rdata=%h err=%b want 4 0 1", lat, rsp_rdata, rsp_err);
    end
    checks++;
    if (!di) begin
      errors++; $display("FAIL error_htrans: HTRANS left IDLE in data phase");
    end
    extra = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL error_single_rsp: %0d extra rsp_valid cycles, want 0", extra);
    end
  endtask

  task automatic test_misaligned();
    int lat, ns; logic [31:0] aa, dw; logic [2:0] as; logic aw, hs, di; rsp_t e;
    logic [31:0] ad [3] = '{32'h4000_0002, 32'h4000_0005, 32'h4000_0000};
    logic [2:0]  sz [3] = '{3'd2, 3'd1, 3'd3};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'd0, 1'b1});
      xfer(1'b0, ad[i], sz[i], 32'h0, 0, 32'h1111_1111, 1'b0, lat, ns, aa, as, aw, dw, hs, di);
      e = sb.pop_front();
      checks++;
      if (lat != 1 || ns != 0 || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
        errors++;
        $display("FAIL misaligned_%0d: lat=%0d nonseq=%0d err=%b rdata=%h want 1 0 1 0",
                 i, lat, ns, rsp_err, rsp_rdata);
      end
      tick();
    end
  endtask

  task automatic test_backpressure_reset();
    int lat, ns, bad; logic [31:0] aa, dw; logic [2:0] as; logic aw, hs, di; rsp_t e;
    rsp_ready = 1'b0;
    sb.push_back('{32'h0000_0033, 1'b0});
    xfer(1'b0, 32'h4000_0041, 3'd0, 32'h0, 0, 32'h1122_3344, 1'b0, lat, ns, aa, as, aw, dw, hs, di);
    e = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) bad++;
      tick();
    end
    checks++;
    if (lat != 3 || bad != 0) begin
      errors++; $display("FAIL backpressure_hold: lat=%0d unstable_cycles=%0d rdata=%h want 3 0 %h",
                         lat, bad, rsp_rdata, e.rdata);
    end
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0020; cmd_size = 3'd2;
    cmd_wdata = 32'hCAFE_F00D; HREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    checks++;
    if (HTRANS !== 2'b00 || HWDATA !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL reset_mid_dataphase: HTRANS=%h HWDATA=%h want 0 cafef00d", HTRANS, HWDATA);
    end
    HRESETn = 1'b0;
    tick();
    checks++;
    if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || HWDATA !== 32'd0) begin
      errors++; $display("FAIL reset_mid_clear: HTRANS=%h rsp_valid=%b cmd_ready=%b HWDATA=%h",
                         HTRANS, rsp_valid, cmd_ready, HWDATA);
    end
    HRESETn = 1'b1; HREADY = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || HTRANS !== 2'b00 || cmd_ready !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_mid_discard: %0d bad cycles after release, want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ns, waits; logic [31:0] aa, dw, a, wd, rd; logic [2:0] as, sz;
    logic aw, hs, di, wr, er; rsp_t e;
    for (int i = 0; i < 10; i++) begin
      sz = 3'($urandom_range(0, 2));
      a  = $urandom;
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
      wr = 1'($urandom);
      wd = $urandom; rd = $urandom;
      waits = $urandom_range(0, 2);
      er = ($urandom_range(0, 3) == 0);
      if (er && waits == 0) waits = 1;
      sb.push_back('{rdata_model(wr, a, sz, rd, er), er});
      xfer(wr, a, sz, wd, waits, rd, er, lat, ns, aa, as, aw, dw, hs, di);
      e = sb.pop_front();
      checks++;
      if (lat != 3 + waits || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++; $display("FAIL b2b_%0d_rsp: lat=%0d rdata=%h err=%b want %0d %h %b",
                           i, lat, rsp_rdata, rsp_err, 3 + waits, e.rdata, e.err);
      end
      checks++;
      if (aa !== a || as !== sz || aw !== wr || (wr && dw !== rep_model(sz, wd)) || !hs) begin
        errors++; $display("FAIL b2b_%0d_bus: HADDR=%h HSIZE=%h HWRITE=%b HWDATA=%h want %h %h %b %h",
                           i, aa, as, aw, dw, a, sz, wr, rep_model(sz, wd));
      end
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d_ready: cmd_ready=%b rsp_valid=%b want 1 0", i, cmd_ready, rsp_valid);
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
    test_reset();
    test_word_write();
    test_byte_write();
    test_hw_read_wait();
    test_error();
    test_misaligned();
    test_backpressure_reset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 Parameter HPROT_VAL, default 4'b0011, is the constant value driven on HPROT (data, privileged, non-bufferable, non-cacheable).
REQ-002 HCLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 HRESETn  input  1  reset, synchronous and active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when both cmd_valid and cmd_ready are 1 at a rising edge.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  byte address.
REQ-008 cmd_size  input  3  AHB size code: 0 byte, 1 halfword, 2 word.
REQ-009 cmd_wdata  input  32  write data, right-justified.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when both rsp_valid and rsp_ready are 1 at a rising edge.
REQ-012 rsp_rdata  output  32  read data, right-justified, zero-extended.
REQ-013 rsp_err  output  1  1 = bus ERROR or local misalignment reject.
REQ-014 HADDR  output  32, HTRANS  output  2, HWRITE  output  1, HSIZE  output  3, HPROT  output  4, HWDATA  output  32  AHB-Lite master outputs.
REQ-015 HREADY  input  1, HRDATA  input  32, HRESP  input  1  AHB-Lite slave returns.

Function
REQ-016 The FSM SHALL have the states IDLE, ADDR, DATA and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, an accepted aligned command SHALL be registered and the FSM SHALL move to ADDR.
REQ-018 Misaligned commands SHALL go from IDLE straight to RESP with rsp_err=1 and rsp_rdata=0, with no bus transfer: size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size >2.
REQ-019 In ADDR, outputs SHALL be HTRANS=NONSEQ (2'b10) plus registered HADDR, HWRITE and HSIZE; the FSM SHALL move to DATA when HREADY=1 and hold otherwise.
REQ-020 In every state other than ADDR, HTRANS SHALL be IDLE (2'b00), and HADDR, HWRITE and HSIZE SHALL hold their last values.
REQ-021 In DATA, HWDATA SHALL carry the write data with lane replication: byte to all four lanes, halfword to both halves, word unchanged.
REQ-022 HWDATA SHALL be held stable through all DATA wait states (HREADY=0).
REQ-023 In DATA with HREADY=1, the FSM SHALL capture rsp_err=HRESP and move to RESP.
REQ-024 On that capture, for a read with HRESP=0: rsp_rdata = HRDATA lane selected by the registered addr[1:0] (byte) or addr[1] (halfword), zero-extended.
REQ-025 On that capture, for a write, or for an error: rsp_rdata = 0.
REQ-026 A two-cycle ERROR response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) SHALL complete as one errored response.
REQ-027 During that ERROR response, HTRANS SHALL remain IDLE; no cancellation logic is needed because the design is non-pipelined.
REQ-028 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be stable until rsp_ready=1.
REQ-029 On the rsp_valid and rsp_ready handshake the FSM SHALL move to IDLE, and rsp_valid SHALL fall on the same edge.
REQ-030 With zero wait states and rsp_ready held at 1, latency SHALL be: accept at edge N, NONSEQ during cycle N+1, data phase during N+2, rsp_valid during N+3, and cmd_ready again at N+4.
REQ-031 Each wait-state cycle (HREADY=0) SHALL add exactly one cycle of latency.
REQ-032 The block SHALL have at most one outstanding transfer; no address/data phase overlap.
REQ-033 cmd_* inputs outside an accept edge SHALL be ignored.
REQ-034 Changes on cmd_* after acceptance SHALL NOT affect the transfer in flight.

Reset
REQ-035 When HRESETn=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-036 On that reset edge, outputs SHALL clear to: HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-037 HPROT SHALL equal HPROT_VAL at all times, including during reset.
REQ-038 cmd_ready SHALL be 0 while HRESETn=0 and 1 on the first cycle after release.
REQ-039 Reset asserted mid-transfer (ADDR, DATA or RESP) SHALL discard the transfer and any pending response, with HTRANS=IDLE from the next cycle.

Verification
REQ-040 Word write: addr 0x40000000, size 2, wdata 0x12345678, HREADY always 1 -> NONSEQ at N+1, HWDATA=0x12345678 at N+2, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-041 Byte write: addr 0x40000003, wdata 0x000000A5 -> HSIZE=0, HWDATA=0xA5A5A5A5.
REQ-042 Halfword read with 3 wait states: addr 0x40000002, size 1, HRDATA=0xBEEF1234 -> rsp_rdata=0x0000BEEF, rsp_valid at N+6, HWDATA and HTRANS stable throughout.
REQ-043 Two-cycle ERROR on a read: rsp_err=1 and rsp_rdata=0, one response only, HTRANS IDLE throughout the data phase.
REQ-044 Misaligned word read at addr 0x40000002 -> no NONSEQ ever driven, rsp_valid at N+1 with rsp_err=1.
REQ-045 Back-pressure then reset: rsp_ready=0 holds rsp_valid and data for 10 cycles; HRESETn=0 during DATA -> rsp_valid stays 0, cmd_ready=1 one cycle after release.
